// File: rtl/rock_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rock_field_ctrl
// Purpose  : Playfield controller for NUM_ROCKS independent falling rocks.
//            Each rock runs IDLE -> WOBBLE -> FALL -> LAND -> GONE, driven by
//            a frame tick taken from the rising edge of frame_clk_i.
//            Provides the pixel hit flag / lowest hit index for the pixel mux
//            and falling / deleted / crush status for game logic.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            frame_clk_i         - vsync-rate strobe (edge detected here)
//            restart_i           - sync reload of all rocks to start positions
//            draw_x_i/draw_y_i   - current pixel
//            rock_start_x_i/_y_i - start centre per rock, rock i at [10i+9:10i]
//            dug_map_i           - tile (c,r) at bit c*GRID_ROWS+r, 1 = dug
//            player_x_i/_y_i     - player centre
//            is_rock_o/rock_id_o - pixel hit flag and lowest hit rock index
//            rock_x_o/rock_y_o   - current centre per rock
//            falling_o/deleted_o - per-rock FALL / GONE flags
//            crush_o             - one-clk pulse, falling rock overlaps player
// Options  : define ROCK_WOBBLE_EN to jitter reported X by +1 px in WOBBLE
// Revision : 1.0 - initial release
// ============================================================================
module rock_field_ctrl #(
  parameter int NUM_ROCKS     = 4,
  parameter int GRID_COLS     = 40,
  parameter int GRID_ROWS     = 24,
  parameter int TOP_Y         = 96,
  parameter int Y_MAX         = 471,
  parameter int WOBBLE_FRAMES = 60,
  parameter int LAND_FRAMES   = 30,
  parameter int FALL_SPEED    = 2,
  localparam int IDW = (NUM_ROCKS > 1) ? $clog2(NUM_ROCKS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           frame_clk_i,
  input  logic                           restart_i,
  input  logic [9:0]                     draw_x_i,
  input  logic [9:0]                     draw_y_i,
  input  logic [10*NUM_ROCKS-1:0]        rock_start_x_i,
  input  logic [10*NUM_ROCKS-1:0]        rock_start_y_i,
  input  logic [GRID_COLS*GRID_ROWS-1:0] dug_map_i,
  input  logic [9:0]                     player_x_i,
  input  logic [9:0]                     player_y_i,
  output logic                           is_rock_o,
  output logic [IDW-1:0]                 rock_id_o,
  output logic [10*NUM_ROCKS-1:0]        rock_x_o,
  output logic [10*NUM_ROCKS-1:0]        rock_y_o,
  output logic [NUM_ROCKS-1:0]           falling_o,
  output logic [NUM_ROCKS-1:0]           deleted_o,
  output logic                           crush_o
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WOBBLE = 3'd1;
  localparam logic [2:0] FALL   = 3'd2;
  localparam logic [2:0] LAND   = 3'd3;
  localparam logic [2:0] GONE   = 3'd4;

  // Timer wide enough for the longer phase; at least 3 bits so the wobble
  // jitter can always look at bit 2.
  localparam int TMAX   = (WOBBLE_FRAMES > LAND_FRAMES) ? WOBBLE_FRAMES : LAND_FRAMES;
  localparam int TW_RAW = $clog2(TMAX + 1);
  localparam int TW     = (TW_RAW < 3) ? 3 : TW_RAW;
  localparam int IDXW   = $clog2(GRID_COLS * GRID_ROWS);

  localparam logic [TW-1:0] WOB_L   = TW'(WOBBLE_FRAMES);
  localparam logic [TW-1:0] LAND_L  = TW'(LAND_FRAMES);
  localparam logic [9:0]    TOP_Y_L = 10'(TOP_Y);
  localparam logic [9:0]    Y_MAX_L = 10'(Y_MAX);
  localparam logic [10:0]   FS_L    = 11'(FALL_SPEED);

  // Frame edge detector: tick for one clk after a registered 0->1 sample.
  logic frame_s_q, frame_p_q, crush_q;
  logic frame_tick;
  logic [NUM_ROCKS-1:0] w_hit, w_crush;

  assign frame_tick = frame_s_q & ~frame_p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_s_q <= 1'b0;
      frame_p_q <= 1'b0;
      crush_q   <= 1'b0;
    end else begin
      frame_s_q <= frame_clk_i;
      frame_p_q <= frame_s_q;
      crush_q   <= ~restart_i & frame_tick & (|w_crush);
    end
  end

  assign crush_o = crush_q;

  for (genvar i = 0; i < NUM_ROCKS; i++) begin : g_rock
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [9:0]    start_x, start_y, y_next, rx;
    logic [10:0]   y_sum;
    logic [5:0]    col;
    logic [6:0]    row;
    logic [IDXW-1:0] idx;
    logic          in_map, below, hit, crush_hit;

    assign start_x = rock_start_x_i[10*i +: 10];
    assign start_y = rock_start_y_i[10*i +: 10];

    // Tile directly under the rock centre; index forced to 0 when off-map.
    assign col    = 6'(x_q >> 4);
    assign row    = 7'((y_q - TOP_Y_L) >> 4) + 7'd1;
    assign in_map = (y_q >= TOP_Y_L) && (32'(row) < GRID_ROWS) && (32'(col) < GRID_COLS);
    assign idx    = in_map ? IDXW'(32'(col) * GRID_ROWS + 32'(row)) : '0;
    assign below  = in_map & dug_map_i[idx];

    assign timer_inc = timer_q + 1'b1;
    assign y_sum     = {1'b0, y_q} + FS_L;
    assign y_next    = (y_sum >= {1'b0, Y_MAX_L}) ? Y_MAX_L : y_sum[9:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        timer_q <= '0;
        x_q     <= start_x;
        y_q     <= start_y;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        x_q     <= x_d;
        y_q     <= y_d;
      end
    end

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      x_d     = x_q;
      y_d     = y_q;
      if (restart_i) begin
        state_d = IDLE;
        timer_d = '0;
        x_d     = start_x;
        y_d     = start_y;
      end else if (frame_tick) begin
        case (state_q)
          IDLE: begin
            if (below) begin
              state_d = WOBBLE;
              timer_d = TW'(1);
            end
          end
          WOBBLE: begin
            if (!below) begin
              state_d = IDLE;
              timer_d = '0;
            end else if (timer_inc >= WOB_L) begin
              state_d = FALL;
              timer_d = '0;
            end else begin
              timer_d = timer_inc;
            end
          end
          FALL: begin
            // Always move this frame; stop once floor or solid tile is met.
            y_d = y_next;
            if ((y_next == Y_MAX_L) || !below) begin
              state_d = LAND;
              timer_d = '0;
            end
          end
          LAND: begin
            if (timer_inc >= LAND_L) begin
              state_d = GONE;
              timer_d = '0;
            end else begin
              timer_d = timer_inc;
            end
          end
          default: state_d = GONE;
        endcase
      end
    end

    always_comb begin
      rx = x_q;
`ifdef ROCK_WOBBLE_EN
      if ((state_q == WOBBLE) && timer_q[2]) rx = x_q + 10'd1;
`endif
      hit = (state_q != GONE) &&
            ({1'b0, draw_x_i} + 11'd8 >= {1'b0, rx}) && ({1'b0, draw_x_i} <= {1'b0, rx} + 11'd8) &&
            ({1'b0, draw_y_i} + 11'd8 >= {1'b0, y_q}) && ({1'b0, draw_y_i} <= {1'b0, y_q} + 11'd8);
      crush_hit = (state_q == FALL) &&
            ({1'b0, x_q} <= {1'b0, player_x_i} + 11'd11) && ({1'b0, player_x_i} <= {1'b0, x_q} + 11'd11) &&
            ({1'b0, y_q} <= {1'b0, player_y_i} + 11'd11) && ({1'b0, player_y_i} <= {1'b0, y_q} + 11'd11);
    end

    assign rock_x_o[10*i +: 10] = rx;
    assign rock_y_o[10*i +: 10] = y_q;
    assign falling_o[i]         = (state_q == FALL);
    assign deleted_o[i]         = (state_q == GONE);
    assign w_hit[i]             = hit;
    assign w_crush[i]           = crush_hit;
  end

  // Lowest-index hit wins: scan downwards so the last write is the lowest.
  always_comb begin
    rock_id_o = '0;
    for (int k = NUM_ROCKS - 1; k >= 0; k--) begin
      if (w_hit[k]) rock_id_o = IDW'(k);
    end
  end

  assign is_rock_o = |w_hit;

endmodule
`default_nettype wire

// File: tb/tb_rock_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rock_field_ctrl
// Purpose  : Directed self-checking bench for rock_field_ctrl. Four rocks run
//            in one shared frame timeline; expected values are hand-derived.
//            GRID_ROWS is raised to 32 so the tile under y=470 is on the map,
//            letting a rock fall from 470 into the Y_MAX clamp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rock_field_ctrl;

  localparam int NR = 4;
  localparam int GC = 40;
  localparam int GR = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 frame_clk_i;
  logic                 restart_i;
  logic [9:0]           draw_x_i, draw_y_i;
  logic [10*NR-1:0]     rock_start_x_i, rock_start_y_i;
  logic [GC*GR-1:0]     dug_map_i;
  logic [9:0]           player_x_i, player_y_i;
  logic                 is_rock_o;
  logic [1:0]           rock_id_o;
  logic [10*NR-1:0]     rock_x_o, rock_y_o;
  logic [NR-1:0]        falling_o, deleted_o;
  logic                 crush_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_crush;
  int total_crush = 0;

  rock_field_ctrl #(.NUM_ROCKS(NR), .GRID_COLS(GC), .GRID_ROWS(GR)) dut (
    .clk(clk), .rst_n(rst_n), .frame_clk_i(frame_clk_i), .restart_i(restart_i),
    .draw_x_i(draw_x_i), .draw_y_i(draw_y_i),
    .rock_start_x_i(rock_start_x_i), .rock_start_y_i(rock_start_y_i),
    .dug_map_i(dug_map_i), .player_x_i(player_x_i), .player_y_i(player_y_i),
    .is_rock_o(is_rock_o), .rock_id_o(rock_id_o),
    .rock_x_o(rock_x_o), .rock_y_o(rock_y_o),
    .falling_o(falling_o), .deleted_o(deleted_o), .crush_o(crush_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int c, input int r, input logic v);
    dug_map_i[c*GR + r] = v;
  endtask

  // One frame: strobe high 4 clks, low 3 clks; counts crush samples seen.
  task automatic frame(output int nc);
    nc = 0;
    frame_clk_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (crush_o) nc++;
    end
    frame_clk_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (crush_o) nc++;
    end
  endtask

  function automatic logic [9:0] ry(input int i);
    return rock_y_o[10*i +: 10];
  endfunction

  initial begin
    rst_n       = 1'b0;
    frame_clk_i = 1'b0;
    restart_i   = 1'b0;
    draw_x_i    = 10'd0;
    draw_y_i    = 10'd0;
    player_x_i  = 10'd600;
    player_y_i  = 10'd50;
    dug_map_i   = '0;
    // rock0 (24,104) col1, rock1 (38,104) col2, rock2 (88,104) col5, rock3 (3,470) col0
    rock_start_x_i = {10'd3,   10'd88,  10'd38,  10'd24};
    rock_start_y_i = {10'd470, 10'd104, 10'd104, 10'd104};

    repeat (3) @(negedge clk);
    check("reset_y0",      32'(ry(0)), 104);
    check("reset_x3",      32'(rock_x_o[39:30]), 3);
    check("reset_falling", 32'(falling_o), 0);
    check("reset_deleted", 32'(deleted_o), 0);
    check("reset_crush",   32'(crush_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pixel hits on idle rocks
    draw_x_i = 10'd0;  draw_y_i = 10'd470; #1;
    check("hit_x3_drawx0", 32'(is_rock_o), 1);
    check("id_x3_drawx0",  32'(rock_id_o), 3);
    draw_x_i = 10'd31; draw_y_i = 10'd104; #1;
    check("hit_overlap",   32'(is_rock_o), 1);
    check("id_overlap",    32'(rock_id_o), 0);
    draw_x_i = 10'd46; #1;
    check("id_rock1_only", 32'(rock_id_o), 1);
    draw_x_i = 10'd700; draw_y_i = 10'd10; #1;
    check("miss",          32'(is_rock_o), 0);
    check("miss_id",       32'(rock_id_o), 0);

    // Undermine all rocks
    for (int r = 1; r <= 12; r++) set_tile(1, r, 1'b1);
    set_tile(2, 1, 1'b1); set_tile(2, 2, 1'b1);
    set_tile(5, 1, 1'b1); set_tile(5, 2, 1'b1);
    set_tile(0, 24, 1'b1);

    for (int t = 1; t <= 108; t++) begin
      player_x_i = 10'd600; player_y_i = 10'd50;
      if (t == 1)  begin player_x_i = 10'd24; player_y_i = 10'd104; end
      if (t == 70) begin player_x_i = 10'd3;  player_y_i = 10'd471; end
      if (t == 92) begin player_x_i = 10'd88; player_y_i = 10'd109; end
      if (t == 31) set_tile(5, 1, 1'b0);
      if (t == 32) set_tile(5, 1, 1'b1);
      @(negedge clk);
      frame(n_crush);
      total_crush += n_crush;
      if (t == 59) check("wobble_59_fall1", 32'(falling_o[1]), 0);
      if (t == 60) begin
        check("wobble_60_fall1", 32'(falling_o[1]), 1);
        check("fall1_y_start",   32'(ry(1)), 104);
        check("wobble_60_fall3", 32'(falling_o[3]), 1);
      end
      if (t == 61) begin
        check("fall1_y_step",  32'(ry(1)), 106);
        check("ymax_clamp_y3", 32'(ry(3)), 471);
        check("ymax_land3",    32'(falling_o[3]), 0);
      end
      if (t == 72) check("fall1_y_128", 32'(ry(1)), 128);
      if (t == 73) begin
        check("land1_y",    32'(ry(1)), 130);
        check("land1_fall", 32'(falling_o[1]), 0);
      end
      if (t == 90) begin
        check("rewobble_90_fall2", 32'(falling_o[2]), 0);
        check("land3_90_del",      32'(deleted_o[3]), 0);
      end
      if (t == 91) begin
        check("rewobble_91_fall2", 32'(falling_o[2]), 1);
        check("land3_91_del",      32'(deleted_o[3]), 1);
      end
      if (t == 92) check("crush_pulse", 32'(n_crush), 1);
      if (t == 102) check("land1_102_del", 32'(deleted_o[1]), 0);
      if (t == 103) begin
        check("land1_103_del", 32'(deleted_o[1]), 1);
        draw_x_i = 10'd38; draw_y_i = 10'd130; #1;
        check("gone1_no_hit", 32'(is_rock_o), 0);
        check("gone1_id",     32'(rock_id_o), 0);
        draw_x_i = 10'd700; draw_y_i = 10'd10;
      end
      if (t == 108) begin
        check("fall0_y_200", 32'(ry(0)), 200);
        check("fall0_flag",  32'(falling_o[0]), 1);
      end
    end
    check("crush_total", 32'(total_crush), 1);

    // Asynchronous reset mid-fall
    #2 rst_n = 1'b0;
    #1;
    check("async_y0",       32'(ry(0)), 104);
    check("async_falling",  32'(falling_o), 0);
    check("async_deleted",  32'(deleted_o), 0);
    check("async_y3",       32'(ry(3)), 470);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rock_field_ctrl.md
Name: rock_field_ctrl

Overview:
- Multi-rock controller for the playfield; generalises the single-rock block to NUM_ROCKS independent channels.
- Each rock has a per-rock FSM (idle, wobble, fall, land, gone), a configurable fall speed and a land-and-hold phase before removal.
- Adds crush detection against the player box.
- Feeds the pixel mux with the rock hit flag and rock index, and feeds game logic with falling, delete and crush status.

Parameters:
- NUM_ROCKS, 4, number of rock channels
- GRID_COLS, 40, dug-map columns (16 px tiles)
- GRID_ROWS, 24, dug-map rows below TOP_Y
- TOP_Y, 96, pixel Y of dug-map row 0
- Y_MAX, 471, lowest rock centre Y; rock lands here regardless of map
- WOBBLE_FRAMES, 60, frames of continuous undermining before fall starts
- LAND_FRAMES, 30, frames the landed rock stays visible before deletion
- FALL_SPEED, 2, pixels per frame while falling (1..8)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  async active-low reset
- frame_clk  in  1  vsync-rate frame strobe, async to game logic
- restart  in  1  sync level restart; reloads all rocks from start positions
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- rock_start_x  in  10*NUM_ROCKS  start centre X per rock, rock i at [10i+9:10i]
- rock_start_y  in  10*NUM_ROCKS  start centre Y per rock
- dug_map  in  GRID_COLS*GRID_ROWS  1 = tile dug; tile (c,r) at bit c*GRID_ROWS+r
- player_x  in  10  player centre X
- player_y  in  10  player centre Y
- is_rock  out  1  DrawX/DrawY inside any visible rock box
- rock_id  out  $clog2(NUM_ROCKS)  lowest-index hit rock; 0 when is_rock=0
- rock_x  out  10*NUM_ROCKS  current centre X per rock
- rock_y  out  10*NUM_ROCKS  current centre Y per rock
- falling  out  NUM_ROCKS  rock i in FALL
- deleted  out  NUM_ROCKS  rock i in GONE (level)
- crush  out  1  one-Clk pulse: a falling rock overlaps the player this frame

Behaviour:
- Reset_n low (async): all rocks load their start X/Y; state IDLE; timers 0; falling=0; deleted=0; crush=0. The frame edge detector clears.
- restart=1 (sync): same effect as reset on the next Clk. It has priority over frame_tick, including mid-fall.
- frame_tick is a one-Clk pulse, asserted when a registered frame_clk sample is 1 and the previous sample was 0. All FSM, timer and position updates occur only on frame_tick.
- below(i) = dug_map bit at col = x>>4 and row = ((y-TOP_Y)>>4)+1.
  - below(i) = 0 if y < TOP_Y, row >= GRID_ROWS, or col >= GRID_COLS. No out-of-range indexing.
- IDLE:
  - below=1 goes to WOBBLE with timer=1.
- WOBBLE:
  - below=0 returns to IDLE with timer=0.
  - While below=1, timer increments each tick.
  - When timer reaches WOBBLE_FRAMES, goes to FALL with timer=0.
- FALL:
  - y_next = min(y+FALL_SPEED, Y_MAX).
  - If y_next = Y_MAX, or below evaluated at the current y is 0, position snaps to y_next and the state goes to LAND.
  - A landing requires at least one frame of motion; FALL lasts 1 frame minimum.
- LAND:
  - Timer counts LAND_FRAMES ticks, then goes to GONE.
  - falling=0 on entry.
- GONE: terminal until reset/restart. deleted=1; excluded from is_rock and crush.
- X never changes.
- falling and deleted are registered: valid the Clk after the frame_tick transition.
- Pixel hit: DrawX+8 >= x and DrawX <= x+8, and the same for Y. All compares use 11-bit unsigned, so there is no underflow near 0. Combinational from registered positions.
- Crush: evaluated on frame_tick for rocks in FALL. Hit when |rock_x - player_x| < 12 and |rock_y - player_y| < 12. crush pulses one Clk, 1 cycle after frame_tick. Multiple rocks still give a single pulse.
- Rocks are fully independent; simultaneous events on different rocks are all processed in the same tick.

Optional Feature:
- ROCK_WOBBLE_EN defined:
  - In WOBBLE, the reported rock_x (and the hit box) is offset by +1 px for frames where timer[2]=1, otherwise +0.
  - The stored X is unchanged; the offset clears in FALL.
- Not defined: no offset; rock_x always equals the start X.

Test Plan:
- Reset_n low mid-fall of rock 0 (y=200) -> rock_y[0]=start_y, falling=0, deleted=0 immediately (async).
- Dig tile below rock 1 and hold -> WOBBLE for 60 ticks, falling[1]=1 after the 60th tick, y advances 2 px per tick.
- Undermine rock 2 for 30 ticks, then clear the dug bit -> back to IDLE, timer 0. Re-dig -> a full 60 ticks are required again.
- Rock falls onto an undug tile -> LAND. After 30 ticks deleted=1, is_rock=0 over its box.
- Rock start_y=470 with FALL_SPEED=2 -> lands at exactly 471, no overshoot. Rock at x=3 with DrawX=0 -> is_rock=1 (no underflow).
- Player 5 px below a falling rock -> a single 1-Clk crush pulse. A landed or idle rock overlapping the player -> no crush. Two rocks hitting DrawX/DrawY -> rock_id = lower index.
